di_periph_bridge: RTL

//  Device-interface (di) terminal stage downstream of HostInterface: claims one endpoint address,

---
 rtl/di_periph_bridge.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/di_periph_bridge.sv
// Device-interface endpoint bridge: turns single-cycle read/write strobes into a
// four-phase req/ack handshake to a slow peripheral, with timeout and overrun tracking.
module di_periph_bridge #(
  parameter logic [15:0] EP_ADDR        = 16'h0010,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [15:0] TIMEOUT_DATA   = 16'hDEAD
) (
  input  logic        if_clock,
  input  logic        reset,
  input  logic [15:0] diEpAddr,
  input  logic [15:0] diRegAddr,
  input  logic [15:0] diRegDataIn,
  input  logic        diWrite,
  input  logic        diRead,
  output logic [15:0] diRegDataOut,
  output logic        rdwr_ready,
  output logic        periph_req,
  output logic        periph_we,
  output logic [15:0] periph_addr,
  output logic [15:0] periph_wdata,
  input  logic        periph_ack,
  input  logic [15:0] periph_rdata,
  output logic        timeout_flag,
  output logic        overrun_flag,
  input  logic        flag_clear
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned TW = 16;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            ready_q, ready_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            tout_q, tout_d;
  logic            ovr_q, ovr_d;

  logic            ep_match;
  logic            strobe;
  logic            timer_last;
  logic [TW-1:0]   timer_inc;

  assign ep_match   = (diEpAddr == EP_ADDR);
  assign strobe     = ep_match & (diRead | diWrite);
  assign timer_last = (timer_q == TIMER_LAST);
  // Saturating increment so a huge timeout can never wrap back to zero.
  assign timer_inc  = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + TW'(1);

  always_ff @(posedge if_clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      timer_q <= '0;
      tout_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      timer_q <= timer_d;
      tout_q  <= tout_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    timer_d = timer_q;
    tout_d  = tout_q;
    ovr_d   = ovr_q;

    // Clear first so that any set below in the same cycle takes priority.
    if (flag_clear) begin
      tout_d = 1'b0;
      ovr_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (strobe) begin
          we_d    = diWrite;
          addr_d  = diRegAddr;
          wdata_d = diRegDataIn;
          req_d   = 1'b1;
          ready_d = 1'b0;
          timer_d = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        timer_d = timer_inc;
        if (periph_ack) begin
          req_d   = 1'b0;
          timer_d = '0;
          if (!we_q) rdata_d = periph_rdata;
          state_d = ST_RELEASE;
        end else if (timer_last) begin
          req_d   = 1'b0;
          tout_d  = 1'b1;
          if (!we_q) rdata_d = TIMEOUT_DATA;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_RELEASE: begin
        if (!periph_ack) begin
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end else if (timer_last) begin
          tout_d  = 1'b1;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A claimed strobe while busy is dropped but remembered.
    if (strobe && (state_q != ST_IDLE)) ovr_d = 1'b1;
  end

  assign rdwr_ready   = ready_q;
  assign periph_req   = req_q;
  assign periph_we    = we_q;
  assign periph_addr  = addr_q;
  assign periph_wdata = wdata_q;
  assign timeout_flag = tout_q;
  assign overrun_flag = ovr_q;
  assign diRegDataOut = ep_match ? rdata_q : '0;

endmodule
